// File: rtl/seg_scan_arbiter_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
// Segment codes are {a,b,c,d,e,f,g,dp} with bit7 = a.
package seg_scan_arbiter_pkg;

    typedef logic [3:0] nib_t;

    localparam nib_t       NIB_DASH  = 4'hA;
    localparam nib_t       NIB_BLANK = 4'hF;

    localparam logic [7:0] SEG_DASH  = 8'b0000_0010;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD nibble to seven-segment code; 0xA is a dash, 0xB-0xF blank.
module seg_decode
    import seg_scan_arbiter_pkg::*;
(
    input  nib_t       i_nib,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0:     o_seg = 8'b1111_1100;
            4'h1:     o_seg = 8'b0110_0000;
            4'h2:     o_seg = 8'b1101_1010;
            4'h3:     o_seg = 8'b1111_0010;
            4'h4:     o_seg = 8'b0110_0110;
            4'h5:     o_seg = 8'b1011_0110;
            4'h6:     o_seg = 8'b1011_1110;
            4'h7:     o_seg = 8'b1110_0000;
            4'h8:     o_seg = 8'b1111_1110;
            4'h9:     o_seg = 8'b1111_0110;
            NIB_DASH: o_seg = SEG_DASH;
            default:  o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Shares the 8-digit multiplexed display between fixed-priority requesters;
// ownership changes only at frame boundaries, outputs load one cycle after each scan tick.
module seg_scan_arbiter
    import seg_scan_arbiter_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int SCAN_DIV  = 200000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   digits,
    input  logic [NREQ*8-1:0]    blink_mask,
    output logic [NREQ-1:0]      gnt,
    output logic                 frame_done,
    output logic [7:0]           seg_data1,
    output logic [7:0]           seg_data2,
    output logic [7:0]           seg_which
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [2:0]         r_idx;
    logic               r_tick_d;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic [NREQ-1:0]    r_gnt;
    logic [7:0]         r_seg;
    logic [7:0]         r_which;

    logic               w_tick;
    logic               w_frame_end;
    logic [NREQ-1:0]    w_arb;
    logic [31:0]        w_own_digits;
    logic [7:0]         w_own_mask;
    logic [2:0]         w_pos;
    nib_t               w_nib;
    logic [7:0]         w_seg;
    logic               w_blank;
    logic               w_idle;

    assign w_tick      = (r_scan_cnt == SCAN_LAST);
    assign w_frame_end = w_tick && (r_idx == 3'd7);

    // Lowest set request wins: iterate downward so the last hit is the lowest index.
    always_comb begin
        w_arb = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_arb    = '0;
                w_arb[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_own_digits = '0;
        w_own_mask   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_own_digits = w_own_digits | digits[32*i +: 32];
                w_own_mask   = w_own_mask   | blink_mask[8*i +: 8];
            end
        end
    end

    // Digit k is the k-th nibble from the left and drives select bit 7-k.
    assign w_pos   = 3'd7 - r_idx;
    assign w_nib   = w_own_digits[{w_pos, 2'b00} +: 4];
    assign w_blank = r_phase & w_own_mask[w_pos];
    assign w_idle  = ~|r_gnt;

    seg_decode u_seg_decode (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_idx       <= '0;
            r_tick_d    <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_gnt       <= '0;
            r_seg       <= '0;
            r_which     <= '0;
        end else begin
            r_tick_d <= w_tick;

            if (w_tick) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end

            if (w_frame_end) begin
                r_gnt <= w_arb;
            end

            // A new owner always starts in the visible half of the blink cycle.
            if (w_frame_end && (w_arb != r_gnt)) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end

            if (r_tick_d) begin
                if (w_idle) begin
                    r_seg   <= SEG_BLANK;
                    r_which <= '0;
                end else begin
                    r_seg   <= w_seg;
                    r_which <= w_blank ? 8'd0 : (8'd1 << w_pos);
                end
            end
        end
    end

    assign gnt        = r_gnt;
    assign frame_done = w_frame_end & ~rst;
    assign seg_data1  = r_seg;
    assign seg_data2  = r_seg;
    assign seg_which  = r_which;

endmodule
